// File: rtl/instr_store.sv
// instr_store
//   On-chip instruction store for the CPU fetch path.
//   A byte-serial loader assembles little-endian instructions and writes them
//   at an auto-incrementing slot. A registered fetch port with a fixed
//   one-cycle latency serves the core. Requests made while no program is
//   loaded, or that point past the loaded region, are flagged.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   load_start       pulse: discard program, restart loading at slot 0
//   load_byte_valid  load_byte carries a program byte this cycle
//   load_byte        program byte, least-significant byte of a word first
//   load_done        pulse: program complete, enter READY
//   loading          high while loading
//   load_count       number of complete instructions stored
//   load_overflow    sticky: a complete word arrived with the store full
//   fetch_req        fetch request
//   fetch_index      slot to read
//   fetch_valid      one-cycle pulse: fetch_data / fetch_error valid
//   fetch_data       fetched instruction (0 on error)
//   fetch_error      request rejected
module instr_store #(
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic                   load_byte_valid,
  input  logic [7:0]             load_byte,
  input  logic                   load_done,
  output logic                   loading,
  output logic [ADDR_WIDTH:0]    load_count,
  output logic                   load_overflow,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_index,
  output logic                   fetch_valid,
  output logic [INSTR_WIDTH-1:0] fetch_data,
  output logic                   fetch_error
);

  localparam int BYTES  = INSTR_WIDTH / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_LANE  = BCNT_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_EMPTY, ST_LOAD, ST_READY} state_t;

  state_t                 state_q, state_d;
  logic [BCNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH:0]    load_count_q, load_count_d;
  logic                   load_overflow_q, load_overflow_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic [INSTR_WIDTH-1:0] word_full;
  logic                   mem_we;
  logic                   fetch_valid_q, fetch_valid_d;
  logic [INSTR_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic                   fetch_error_q, fetch_error_d;
  logic                   fetch_oob;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  // Partial word with the incoming byte merged into the current lane. On the
  // last lane this is the complete word that goes to memory.
  always_comb begin
    word_full = word_q;
    for (int i = 0; i < BYTES; i++) begin
      if (byte_cnt_q == BCNT_W'(i)) word_full[8*i +: 8] = load_byte;
    end
  end

  // Load control
  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    load_count_d    = load_count_q;
    load_overflow_d = load_overflow_q;
    word_d          = word_q;
    mem_we          = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (load_start) begin
          // Restart wins over a coincident byte, which is dropped.
          byte_cnt_d      = '0;
          load_count_d    = '0;
          load_overflow_d = 1'b0;
        end else begin
          if (load_byte_valid) begin
            word_d = word_full;
            if (byte_cnt_q == LAST_LANE) begin
              byte_cnt_d = '0;
              if (load_count_q == FULL_COUNT) begin
                load_overflow_d = 1'b1;
              end else begin
                mem_we       = 1'b1;
                load_count_d = load_count_q + 1'b1;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
          // A byte in the same cycle is processed first; any partial word
          // still pending is then discarded.
          if (load_done) begin
            state_d    = ST_READY;
            byte_cnt_d = '0;
          end
        end
      end
      default: begin
        if (load_start) begin
          state_d         = ST_LOAD;
          byte_cnt_d      = '0;
          load_count_d    = '0;
          load_overflow_d = 1'b0;
        end
      end
    endcase
  end

  // Fetch port: evaluated against the pre-edge state and count
  always_comb begin
    fetch_valid_d = fetch_req;
    fetch_data_d  = fetch_data_q;
    fetch_error_d = fetch_error_q;
    fetch_oob     = ({1'b0, fetch_index} >= load_count_q);
    if (fetch_req) begin
      if ((state_q != ST_READY) || fetch_oob) begin
        fetch_error_d = 1'b1;
        fetch_data_d  = '0;
      end else begin
        fetch_error_d = 1'b0;
        fetch_data_d  = mem[fetch_index];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_EMPTY;
      byte_cnt_q      <= '0;
      load_count_q    <= '0;
      load_overflow_q <= 1'b0;
      fetch_valid_q   <= 1'b0;
      fetch_data_q    <= '0;
      fetch_error_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      load_count_q    <= load_count_d;
      load_overflow_q <= load_overflow_d;
      fetch_valid_q   <= fetch_valid_d;
      fetch_data_q    <= fetch_data_d;
      fetch_error_q   <= fetch_error_d;
    end
  end

  // Assembly buffer and storage carry no reset; lanes are always rewritten
  // before a word is committed.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (mem_we) mem[load_count_q[ADDR_WIDTH-1:0]] <= word_full;
  end

  assign loading       = (state_q == ST_LOAD);
  assign load_count    = load_count_q;
  assign load_overflow = load_overflow_q;
  assign fetch_valid   = fetch_valid_q;
  assign fetch_data    = fetch_data_q;
  assign fetch_error   = fetch_error_q;

endmodule

// File: tb/tb_instr_store.sv
module tb_instr_store;

  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic          load_byte_valid;
  logic [7:0]    load_byte;
  logic          load_done;
  logic          loading;
  logic [AW:0]   load_count;
  logic          load_overflow;
  logic          fetch_req;
  logic [AW-1:0] fetch_index;
  logic          fetch_valid;
  logic [IW-1:0] fetch_data;
  logic          fetch_error;

  instr_store #(.INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_start      (load_start),
    .load_byte_valid (load_byte_valid),
    .load_byte       (load_byte),
    .load_done       (load_done),
    .loading         (loading),
    .load_count      (load_count),
    .load_overflow   (load_overflow),
    .fetch_req       (fetch_req),
    .fetch_index     (fetch_index),
    .fetch_valid     (fetch_valid),
    .fetch_data      (fetch_data),
    .fetch_error     (fetch_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [IW:0] exp_q[$];   // {fetch_error, fetch_data} expected per request

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=0x%0h expected=0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_loading"},   32'(loading), 32'd0);
    chk({tag, "_count"},     32'(load_count), 32'd0);
    chk({tag, "_overflow"},  32'(load_overflow), 32'd0);
    chk({tag, "_fvalid"},    32'(fetch_valid), 32'd0);
    chk({tag, "_fdata"},     32'(fetch_data), 32'd0);
    chk({tag, "_ferror"},    32'(fetch_error), 32'd0);
  endtask

  // One clock: outputs are sampled 1 time unit after the edge, then all
  // pulse inputs are dropped.
  task automatic tick();
    logic had_req;
    logic [IW:0] e;
    had_req = fetch_req;
    @(posedge clk);
    #1;
    if (had_req) begin
      e = exp_q.pop_front();
      chk("fetch_valid", 32'(fetch_valid), 32'd1);
      chk("fetch_error", 32'(fetch_error), 32'(e[IW]));
      chk("fetch_data",  32'(fetch_data),  32'(e[IW-1:0]));
    end else begin
      chk("fetch_valid_idle", 32'(fetch_valid), 32'd0);
    end
    load_start      = 1'b0;
    load_done       = 1'b0;
    load_byte_valid = 1'b0;
    fetch_req       = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    load_byte_valid = 1'b1;
    load_byte       = b;
    tick();
  endtask

  task automatic req(input logic [AW-1:0] idx, input logic err, input logic [IW-1:0] data);
    fetch_req   = 1'b1;
    fetch_index = idx;
    exp_q.push_back({err, data});
    tick();
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_byte_valid = 1'b0; load_byte = '0;
    load_done = 1'b0; fetch_req = 1'b0; fetch_index = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    // Fetch with no program loaded
    req(2'd0, 1'b1, 16'h0000);
    chk("empty_count", 32'(load_count), 32'd0);

    // Two-word program
    load_start = 1'b1; tick();
    chk("loading_hi", 32'(loading), 32'd1);
    send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    load_done = 1'b1; tick();
    chk("prog2_count", 32'(load_count), 32'd2);
    chk("prog2_loading", 32'(loading), 32'd0);
    req(2'd0, 1'b0, 16'h1234);
    req(2'd1, 1'b0, 16'h5678);
    req(2'd2, 1'b1, 16'h0000);

    // Partial trailing word discarded
    load_start = 1'b1; tick();
    send(8'hAA); send(8'hBB); send(8'hCC);
    load_done = 1'b1; tick();
    chk("partial_count", 32'(load_count), 32'd1);
    req(2'd0, 1'b0, 16'hBBAA);
    req(2'd1, 1'b1, 16'h0000);
    load_start = 1'b1; tick();
    send(8'h11); send(8'h22);
    load_done = 1'b1; tick();
    req(2'd0, 1'b0, 16'h2211);

    // Bytes outside LOAD are ignored
    send(8'hEE); send(8'hFF);
    chk("ready_bytes_count", 32'(load_count), 32'd1);
    req(2'd0, 1'b0, 16'h2211);

    // Overflow: five words into four slots
    load_start = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      send(8'h10 + 8'(i));
      send(8'hA0 + 8'(i));
      if (i == 3) chk("full_no_ovf", 32'(load_overflow), 32'd0);
    end
    chk("ovf_count", 32'(load_count), 32'd4);
    chk("ovf_flag", 32'(load_overflow), 32'd1);
    load_done = 1'b1; tick();
    chk("ovf_sticky", 32'(load_overflow), 32'd1);
    req(2'd3, 1'b0, 16'hA313);

    // Back-to-back fetches; load_start with the third
    req(2'd0, 1'b0, 16'hA010);
    req(2'd1, 1'b0, 16'hA111);
    load_start = 1'b1;
    req(2'd0, 1'b0, 16'hA010);
    chk("restart_ovf_clr", 32'(load_overflow), 32'd0);
    chk("restart_count", 32'(load_count), 32'd0);
    chk("restart_loading", 32'(loading), 32'd1);
    tick();
    chk("fdata_hold", 32'(fetch_data), 32'hA010);
    req(2'd0, 1'b1, 16'h0000);

    // Byte together with load_done completes the word
    send(8'h01);
    load_done = 1'b1; send(8'h02);
    chk("done_byte_count", 32'(load_count), 32'd1);
    chk("done_byte_loading", 32'(loading), 32'd0);
    req(2'd0, 1'b0, 16'h0201);

    // Asynchronous reset mid-load
    load_start = 1'b1; tick();
    send(8'h55); send(8'h66); send(8'h77);
    chk("preRst_count", 32'(load_count), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h99); send(8'h88);
    chk("postRst_count", 32'(load_count), 32'd0);
    chk("postRst_loading", 32'(loading), 32'd0);
    req(2'd0, 1'b1, 16'h0000);
    load_start = 1'b1; tick();
    send(8'h88); send(8'h99);
    load_done = 1'b1; tick();
    req(2'd0, 1'b0, 16'h9988);
    chk("final_count", 32'(load_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_store.md
Name: instr_store

Overview:
- Parametrised on-chip instruction store for the CPU fetch path.
- A byte-serial loader (fed from the host/UART byte stream) assembles little-endian instructions, writes them at an auto-incrementing address and tracks how many are valid.
- A registered fetch port with request/valid handshake serves the core. Fetches outside the loaded region, or made while no program is loaded, are flagged.

Parameters:
- INSTR_WIDTH, 16, instruction width in bits; must be a multiple of 8, minimum 8.
- DEPTH, 256, number of instruction slots; power of two, ≥2.
- ADDR_WIDTH, $clog2(DEPTH), derived; do not override.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  pulse: discard current program, enter LOAD, pointers to 0.
- load_byte_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  next program byte, little-endian within an instruction.
- load_done  in  1  pulse: end of program; enter READY.
- loading  out  1  high while in LOAD.
- load_count  out  ADDR_WIDTH+1  number of complete instructions stored.
- load_overflow  out  1  sticky: a complete word arrived with store full.
- fetch_req  in  1  fetch request, sampled each rising edge.
- fetch_index  in  ADDR_WIDTH  instruction slot to read.
- fetch_valid  out  1  one-cycle pulse: fetch_data / fetch_error valid.
- fetch_data  out  INSTR_WIDTH  fetched instruction.
- fetch_error  out  1  qualifies fetch_valid: request rejected, data is 0.

Behaviour:
- Reset values:
  - State EMPTY.
  - loading=0, load_count=0, load_overflow=0.
  - fetch_valid=0, fetch_data=0, fetch_error=0.
  - Byte counter and write pointer 0.
  - Memory array is not reset; contents are undefined.
- Reset is asynchronous and can occur mid-load or mid-fetch. All above values apply immediately. No write may occur in the cycle reset deasserts unless stimulus requests one.
- States: EMPTY, LOAD, READY.
  - EMPTY -> LOAD on load_start.
  - LOAD -> READY on load_done.
  - READY -> LOAD on load_start.
  - load_start in LOAD restarts the load: load_count=0, byte counter=0, load_overflow cleared.
  - load_done in EMPTY or READY is ignored.
- Byte assembly (LOAD only); BYTES = INSTR_WIDTH/8.
  - Each load_byte_valid places load_byte into byte lane byte_cnt and increments byte_cnt.
  - On the last lane, the full word is written to mem[load_count] on that same edge, load_count increments and byte_cnt returns to 0.
  - If load_count == DEPTH when a word completes: no write, load_count holds, load_overflow=1 (sticky until the next load_start or reset).
  - load_byte_valid outside LOAD is ignored.
- Simultaneous events:
  - load_start + load_byte_valid: start wins, byte dropped.
  - load_done + load_byte_valid: byte processed first (may complete and write a word), then go to READY.
  - A partial word pending at load_done is discarded and byte_cnt is cleared.
- Fetch: fixed 1-cycle latency.
  - A fetch_req sampled at edge k sets fetch_valid=1 with fetch_data/fetch_error from edge k. fetch_valid is high for exactly the cycle after edge k.
  - Back-to-back requests produce back-to-back valids. There is no backpressure.
  - Error case: fetch_error=1 and fetch_data=0 if state != READY, or if fetch_index >= load_count.
  - Otherwise fetch_error=0 and fetch_data = mem[fetch_index].
  - Without fetch_req, fetch_valid=0; fetch_data and fetch_error hold their last values.
- A fetch in the same cycle as load_start is evaluated against the pre-edge state (READY). The following cycles error.
- Memory: one write port and one read port, both synchronous on rising edge. Read and write never target valid data in the same cycle, because fetch is only serviced in READY.

Test Plan:
- Reset, then fetch_req index 0 -> fetch_valid=1 and fetch_error=1 next cycle, fetch_data=0; load_count=0.
- load_start; bytes 0x34,0x12,0x78,0x56; load_done -> load_count=2, loading falls. Fetch index 0 -> 0x1234; fetch index 1 -> 0x5678; fetch index 2 -> error.
- Load 3 bytes 0xAA,0xBB,0xCC then load_done -> load_count=1, mem[0]=0xBBAA. Fetch index 1 -> error. A new load_start then starts at lane 0.
- DEPTH=4: load 5 words -> load_count=4, load_overflow=1, mem[3] = the 4th word. Next load_start clears load_overflow.
- Back-to-back fetch_req indices 0,1,0 in READY -> three consecutive fetch_valid pulses with the matching data. load_start asserted with the third request -> third returns data, the next request errors.
- Assert rst_n=0 mid-load after 1 byte -> outputs return to reset values asynchronously. Subsequent load_byte_valid is ignored until load_start.
